// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: datapath width, FSM state
// encodings, default reset PC and the instruction size used for PC+4.
package pc_fetch_sequencer_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bytes per instruction; the sequential PC step.
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pc_fetch_sequencer_target_calc.sv
// pc_target_calc: combinational control-flow target generator.
// Ports:
//   pc_i         current instruction address
//   rs1_i        register base for the JALR form
//   imm_i        sign-extended immediate
//   jalr_i       1 = (rs1 + imm) & ~1, 0 = pc + imm
//   target_o     computed target (adds wrap mod 2^W)
//   misaligned_o target bit[1] set; bit 0 is never a fault (cleared for
//                JALR, always zero for PC-relative)
module pc_target_calc
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] rs1_i,
  input  logic [W-1:0] imm_i,
  input  logic         jalr_i,
  output logic [W-1:0] target_o,
  output logic         misaligned_o
);

  logic [W-1:0] base;
  logic [W-1:0] sum;

  assign base = jalr_i ? rs1_i : pc_i;
  assign sum  = base + imm_i;

  always_comb begin
    target_o = sum;
    if (jalr_i) begin
      target_o[0] = 1'b0;
    end
  end

  assign misaligned_o = target_o[1];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC, sequences each instruction
// through an imem fetch handshake and an execute cycle, and halts in a trap
// state when a taken control-flow target is not 4-byte aligned.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_take, i_jalr      branch decision and target form
//   i_imm, i_rs1        immediate and JALR base
//   i_stall             hold the executing instruction
//   i_imem_ready        imem accepted the fetch request
//   o_imem_req          fetch request for o_pc
//   o_pc, o_pc_plus4    current address and its link value
//   o_instr_valid       instruction at o_pc executing this cycle
//   o_misaligned        sticky misaligned-target flag
//   o_trap_pc           offending target
//   o_halted            in TRAP
//   o_retired           completed-instruction count (wraps)
//
// state    | meaning
// ST_FETCH | request outstanding, wait for i_imem_ready
// ST_EXEC  | instruction executing; completes when i_stall=0
// ST_TRAP  | misaligned target seen; only reset leaves
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                              DATA_WIDTH = pc_fetch_sequencer_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]           RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_take,
  input  logic                  i_jalr,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic                  i_stall,
  input  logic                  i_imem_ready,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic                  o_instr_valid,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_trap_pc,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_retired
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic [DATA_WIDTH-1:0] retired_q, retired_d;
  logic                  mis_q, mis_d;

  logic [DATA_WIDTH-1:0] target;
  logic                  target_mis;
  logic                  exec_go;
  logic                  trap_hit;

  pc_target_calc #(
    .W(DATA_WIDTH)
  ) u_target (
    .pc_i         (pc_q),
    .rs1_i        (i_rs1),
    .imm_i        (i_imm),
    .jalr_i       (i_jalr),
    .target_o     (target),
    .misaligned_o (target_mis)
  );

  // Branch inputs only matter on the cycle the instruction completes.
  assign exec_go  = (state_q == ST_EXEC) && !i_stall;
  assign trap_hit = exec_go && i_take && target_mis;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (i_imem_ready) state_d = ST_EXEC;
      ST_EXEC: begin
        if (trap_hit) begin
          state_d = ST_TRAP;
        end else if (exec_go) begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    case (state_q)
      ST_FETCH: o_imem_req    = 1'b1;
      ST_EXEC:  o_instr_valid = 1'b1;
      ST_TRAP:  o_halted      = 1'b1;
      default:  o_imem_req    = 1'b0;
    endcase
  end

  // On a trap the PC and retire count hold so o_pc still names the
  // faulting instruction.
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    mis_d     = mis_q;
    trap_pc_d = trap_pc_q;
    if (trap_hit) begin
      mis_d     = 1'b1;
      trap_pc_d = target;
    end else if (exec_go) begin
      pc_d      = i_take ? target : pc_q + PC_STEP;
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
      mis_q     <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      mis_q     <= mis_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_plus4   = pc_q + PC_STEP;
  assign o_misaligned = mis_q;
  assign o_trap_pc    = trap_pc_q;
  assign o_retired    = retired_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, take, jalr, stall, ready;
  logic [31:0] imm, rs1;

  logic        req, ivalid, mis, halted;
  logic [31:0] pc, pc4, tpc, ret;

  logic        w_req, w_ivalid, w_mis, w_halted;
  logic [31:0] w_pc, w_pc4, w_tpc, w_ret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_take(take), .i_jalr(jalr), .i_imm(imm),
    .i_rs1(rs1), .i_stall(stall), .i_imem_ready(ready),
    .o_imem_req(req), .o_pc(pc), .o_pc_plus4(pc4), .o_instr_valid(ivalid),
    .o_misaligned(mis), .o_trap_pc(tpc), .o_halted(halted), .o_retired(ret)
  );

  pc_fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_take(take), .i_jalr(jalr), .i_imm(imm),
    .i_rs1(rs1), .i_stall(stall), .i_imem_ready(ready),
    .o_imem_req(w_req), .o_pc(w_pc), .o_pc_plus4(w_pc4), .o_instr_valid(w_ivalid),
    .o_misaligned(w_mis), .o_trap_pc(w_tpc), .o_halted(w_halted), .o_retired(w_ret)
  );

  typedef struct {
    logic        rst, take, jalr, stall, ready;
    logic [31:0] imm, rs1;
    logic [31:0] e_pc, e_ret;
    logic        e_req, e_valid, e_halt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic t, input logic j, input logic [31:0] im,
                       input logic [31:0] r1, input logic s, input logic rd);
    rst = r; take = t; jalr = j; imm = im; rs1 = r1; stall = s; ready = rd;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: instruction-level view of the sequencer.
  logic [31:0] m_pc, m_ret, m_tpc;
  logic        m_mis, m_halted, m_have_instr;

  task automatic model_step;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_ret = 0; m_tpc = 0; m_mis = 0; m_halted = 0; m_have_instr = 0;
    end else if (m_halted) begin
      // absorbing
    end else if (!m_have_instr) begin
      if (ready) m_have_instr = 1;
    end else if (!stall) begin
      if (take) begin
        tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
        if (tgt[1]) begin
          m_halted = 1; m_mis = 1; m_tpc = tgt;
        end else begin
          m_pc = tgt; m_ret = m_ret + 1; m_have_instr = 0;
        end
      end else begin
        m_pc = m_pc + 4; m_ret = m_ret + 1; m_have_instr = 0;
      end
    end
  endtask

  initial begin
    //           rst take jalr stall ready imm           rs1           e_pc          e_ret  req valid halt
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,     32'd0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h0,     32'd0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h4,     32'd1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h4,     32'd1, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h8,     32'd2, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h8,     32'd2, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'hC,     32'd3, 1, 0, 0};
    vecs[7]  = '{0, 1, 1, 0, 1, 32'h0,        32'h500,   32'hC,     32'd3, 0, 1, 0};
    vecs[8]  = '{0, 1, 1, 0, 0, 32'h0,        32'h100,   32'h100,   32'd4, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h100,   32'd4, 0, 1, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,    32'hF8,    32'd5, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'hF8,    32'd5, 0, 1, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 32'h28,       32'h0,     32'h120,   32'd6, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h120,   32'd6, 0, 1, 0};
    vecs[14] = '{0, 1, 1, 0, 0, 32'h0,        32'h1001,  32'h1000,  32'd7, 1, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 1, 32'h40,       32'h0,     32'h1000,  32'd7, 0, 1, 0};
    vecs[16] = '{0, 1, 0, 1, 0, 32'h40,       32'h0,     32'h1000,  32'd7, 0, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 1, 32'h40,       32'h0,     32'h1004,  32'd8, 1, 0, 0};

    drive(1, 0, 0, 0, 0, 0, 0);
    tick;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].take, vecs[i].jalr, vecs[i].imm, vecs[i].rs1,
            vecs[i].stall, vecs[i].ready);
      tick;
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_pc4", i), pc4, vecs[i].e_pc + 32'd4);
      chk($sformatf("vec%0d_ret", i), ret, vecs[i].e_ret);
      chk($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d_valid", i), {31'b0, ivalid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d_halt", i), {31'b0, halted}, {31'b0, vecs[i].e_halt});
      chk($sformatf("vec%0d_mis", i), {31'b0, mis}, 32'd0);
    end

    // Stall for three cycles with take asserted, then a single update.
    drive(0, 0, 0, 0, 0, 0, 1); tick;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h40, 0, 1, 1); tick;
      chk("stall_pc", pc, 32'h1004);
      chk("stall_ret", ret, 32'd8);
      chk("stall_valid", {31'b0, ivalid}, 32'd1);
    end
    drive(0, 1, 0, 32'h40, 0, 0, 0); tick;
    chk("stall_rel_pc", pc, 32'h1044);
    chk("stall_rel_ret", ret, 32'd9);
    chk("stall_rel_req", {31'b0, req}, 32'd1);

    // Misaligned JALR target traps and holds until reset.
    drive(0, 0, 0, 0, 0, 0, 1); tick;
    drive(0, 1, 1, 32'h0, 32'h2002, 0, 0); tick;
    chk("trap_halt", {31'b0, halted}, 32'd1);
    chk("trap_mis", {31'b0, mis}, 32'd1);
    chk("trap_tpc", tpc, 32'h2002);
    chk("trap_pc", pc, 32'h1044);
    chk("trap_ret", ret, 32'd9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h4, 0, 0, 1); tick;
      chk("trap_hold_halt", {31'b0, halted}, 32'd1);
      chk("trap_hold_pc", pc, 32'h1044);
      chk("trap_hold_req", {31'b0, req}, 32'd0);
    end
    drive(1, 0, 0, 0, 0, 0, 0); tick;
    chk("trap_rst_pc", pc, 32'h0);
    chk("trap_rst_mis", {31'b0, mis}, 32'd0);
    chk("trap_rst_tpc", tpc, 32'h0);
    chk("trap_rst_req", {31'b0, req}, 32'd1);

    // imem not ready: request held, PC stable.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h8, 0, 0, 0); tick;
      chk("wait_req", {31'b0, req}, 32'd1);
      chk("wait_pc", pc, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 1); tick;
    drive(0, 0, 0, 0, 0, 0, 0); tick;
    chk("seq_pc", pc, 32'h4);
    drive(0, 0, 0, 0, 0, 0, 1); tick;
    chk("exec_valid", {31'b0, ivalid}, 32'd1);
    drive(1, 1, 0, 32'h40, 0, 0, 1); tick;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_ret", ret, 32'd0);
    chk("midrst_req", {31'b0, req}, 32'd1);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_pc4", w_pc4, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1); tick;
    drive(0, 0, 0, 0, 0, 0, 0); tick;
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_ret", w_ret, 32'd1);
    chk("wrap_halt", {31'b0, w_halted}, 32'd0);

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step; tick;
    begin
      int halt_cnt = 0;
      for (int n = 0; n < 500; n++) begin
        logic r;
        r = ($urandom_range(0, 59) == 0) || (halt_cnt > 3);
        drive(r, $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom & 32'hFFFF_FFFC),
              ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
        model_step;
        tick;
        halt_cnt = m_halted ? halt_cnt + 1 : 0;
        chk("rnd_pc", pc, m_pc);
        chk("rnd_pc4", pc4, m_pc + 32'd4);
        chk("rnd_ret", ret, m_ret);
        chk("rnd_mis", {31'b0, mis}, {31'b0, m_mis});
        chk("rnd_tpc", tpc, m_tpc);
        chk("rnd_halt", {31'b0, halted}, {31'b0, m_halted});
        chk("rnd_valid", {31'b0, ivalid}, {31'b0, (!m_halted && m_have_instr)});
        chk("rnd_req", {31'b0, req}, {31'b0, (!m_halted && !m_have_instr)});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
